// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg
//   Shared definitions for the CPU ALU interface: opcode encodings, the
//   position of the opcode field inside the ALU instruction word, flag bit
//   indices and the issue-controller FSM state encoding.
//   No ports; imported with "import cpu_alu_pkg::*;".
`timescale 1ns/1ps

package cpu_alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_NONE = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd5;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd6;
  localparam logic [OP_W-1:0] OP_AND  = 5'd7;
  localparam logic [OP_W-1:0] OP_OR   = 5'd8;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd10;
  localparam logic [OP_W-1:0] OP_CMP  = 5'd11;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd12;

  // Opcode field inside a 32-bit ALU instruction word; the remaining bits are zero.
  localparam int OP_FIELD_MSB = 31;
  localparam int OP_FIELD_LSB = 27;

  // Bit positions inside the 4-bit flag vectors {error, above, equal, below}.
  localparam int FLG_BELOW = 0;
  localparam int FLG_EQUAL = 1;
  localparam int FLG_ABOVE = 2;
  localparam int FLG_ERROR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Only opcodes ADD..NOT are understood by the ALU.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the CPU ALU interface. Accepts one operation over a
//   valid/ready request port, presents the latched operands and opcode to the
//   combinational ALU for SETTLE_CYCLES cycles, captures result and flags and
//   returns them over a valid/ready response port. Also keeps the
//   architectural flag register used by branch logic.
//
//   Ports
//     clk, rst_n                  clock (rising edge), async active-low reset
//     req_valid/req_ready         request handshake (ready only in IDLE)
//     req_op/req_a/req_b          opcode and operands
//     alu_operand_a/_b, alu_instr drive to the ALU; alu_instr is zero outside ISSUE
//     alu_result, alu_below/equal/above/error   ALU outputs
//     rsp_valid/rsp_ready         response handshake
//     rsp_result, rsp_flags       captured result and {error,above,equal,below}
//     flags_q, flags_clr          architectural flag register and its clear
//
//   Configuration macro: ALU_LOCAL_DIV0_EN
//     Defined:   DIV by zero is detected at accept time and answered locally
//                (result 0, error 1) without ever reaching the ALU.
//     Undefined: DIV by zero is issued and the error comes from alu_error.
`timescale 1ns/1ps

module alu_issue_ctrl
  import cpu_alu_pkg::*;
#(
  parameter int DWIDTH        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  output logic [DWIDTH-1:0] alu_operand_a,
  output logic [DWIDTH-1:0] alu_operand_b,
  output logic [DWIDTH-1:0] alu_instr,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_below,
  input  logic              alu_equal,
  input  logic              alu_above,
  input  logic              alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [3:0]        flags_q,
  input  logic              flags_clr
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t            state, state_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic [DWIDTH-1:0] a_q, a_n;
  logic [DWIDTH-1:0] b_q, b_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DWIDTH-1:0] result_q, result_n;
  logic [3:0]        rflags_q, rflags_n;
  logic [3:0]        flags_reg, flags_n;
  logic              ready_en;
  logic              div0_local;

  // Local divide-by-zero detection only exists in the configured build.
`ifdef ALU_LOCAL_DIV0_EN
  assign div0_local = (req_op == OP_DIV) && (req_b == '0);
`else
  assign div0_local = 1'b0;
`endif

  // ready_en keeps req_ready low while reset is asserted and for the first
  // cycle after release, so every output reads zero during reset.
  assign req_ready     = (state == ST_IDLE) && ready_en;
  assign rsp_valid     = (state == ST_RESP);
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign rsp_result    = result_q;
  assign rsp_flags     = rflags_q;
  assign flags_q       = flags_reg;

  // The ALU only sees a real opcode while ISSUE holds its inputs stable;
  // the rest of the time it sits in its default (all-zero) branch.
  always_comb begin
    alu_instr = '0;
    if (state == ST_ISSUE) begin
      alu_instr[DWIDTH-1 -: OP_W] = op_q;
    end
  end

  // Next-state, operand latching, capture and flag-register update.
  // A flag clear is applied first so that any flag set by a capture in the
  // same cycle survives it. Flags are only sampled for the ops that define
  // them because the ALU leaves stale flags from earlier operations.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    cnt_n    = cnt;
    result_n = result_q;
    rflags_n = rflags_q;
    flags_n  = flags_clr ? 4'b0000 : flags_reg;

    case (state)
      ST_IDLE: begin
        if (req_valid && ready_en) begin
          op_n = req_op;
          a_n  = req_a;
          b_n  = (req_op == OP_NOT) ? '0 : req_b;
          if (!is_legal_op(req_op) || div0_local) begin
            state_n             = ST_RESP;
            result_n            = '0;
            rflags_n            = 4'b0000;
            rflags_n[FLG_ERROR] = 1'b1;
            flags_n[FLG_ERROR]  = 1'b1;
          end else begin
            state_n = ST_ISSUE;
            cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end

      ST_ISSUE: begin
        if (cnt == '0) begin
          state_n  = ST_RESP;
          result_n = alu_result;
          rflags_n = 4'b0000;
          if (op_q == OP_CMP) begin
            result_n            = '0;
            rflags_n[FLG_BELOW] = alu_below;
            rflags_n[FLG_EQUAL] = alu_equal;
            rflags_n[FLG_ABOVE] = alu_above;
            flags_n[FLG_BELOW]  = alu_below;
            flags_n[FLG_EQUAL]  = alu_equal;
            flags_n[FLG_ABOVE]  = alu_above;
          end else if ((op_q == OP_DIV) && alu_error) begin
            result_n            = '0;
            rflags_n[FLG_ERROR] = 1'b1;
            flags_n[FLG_ERROR]  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      result_q  <= '0;
      rflags_q  <= 4'b0000;
      flags_reg <= 4'b0000;
      ready_en  <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      a_q       <= a_n;
      b_q       <= b_n;
      cnt       <= cnt_n;
      result_q  <= result_n;
      rflags_q  <= rflags_n;
      flags_reg <= flags_n;
      ready_en  <= 1'b1;
    end
  end

  // A compare must report exactly one ordering relation.
  cmp_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
    ((state == ST_ISSUE) && (cnt == '0) && (op_q == OP_CMP))
      |-> $onehot({alu_above, alu_equal, alu_below}));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Scoreboard bench for alu_issue_ctrl. A behavioural ALU (which, like the
//   real one, keeps stale flags across non-compare ops) sits behind the DUT.
//   Expected responses are pushed when a request is driven and popped when
//   the DUT responds. Honours ALU_LOCAL_DIV0_EN for the expected latency.
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

  localparam int DW     = 32;
  localparam int SETTLE = 2;

  localparam logic [4:0] ADD = 5'd3,  SUB = 5'd4,  MUL = 5'd5, DIV = 5'd6;
  localparam logic [4:0] ANDo = 5'd7, ORo = 5'd8,  SHL = 5'd9, SHR = 5'd10;
  localparam logic [4:0] CMP = 5'd11, NOTo = 5'd12;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  fq;
    int          lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_op = 5'd0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [DW-1:0] alu_operand_a, alu_operand_b, alu_instr, alu_result;
  logic          alu_below, alu_equal, alu_above, alu_error;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic [3:0]    flags_q;
  logic          flags_clr = 1'b0;

  int   checkCount = 0;
  int   passCount  = 0;
  exp_t sb[$];
  logic [3:0] fqModel = 4'b0000;

  logic staleBelow = 1'b0, staleEqual = 1'b0, staleAbove = 1'b0, staleError = 1'b0;
  logic [4:0] aluOp;

  alu_issue_ctrl #(.DWIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_instr(alu_instr), .alu_result(alu_result),
    .alu_below(alu_below), .alu_equal(alu_equal),
    .alu_above(alu_above), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .flags_q(flags_q), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return a * b;
      DIV:     return (b == 0) ? 32'hDEADBEEF : a / b;
      ANDo:    return a & b;
      ORo:     return a | b;
      SHL:     return a << b[4:0];
      SHR:     return a >> b[4:0];
      CMP:     return a - b;
      NOTo:    return ~a;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit legalOp(input logic [4:0] op);
    return (op >= 5'd3) && (op <= 5'd12);
  endfunction

  // Behavioural ALU: flags only refresh on the op that defines them.
  assign aluOp      = alu_instr[31:27];
  assign alu_result = refAlu(aluOp, alu_operand_a, alu_operand_b);
  assign alu_below  = (aluOp == CMP) ? (alu_operand_a <  alu_operand_b) : staleBelow;
  assign alu_equal  = (aluOp == CMP) ? (alu_operand_a == alu_operand_b) : staleEqual;
  assign alu_above  = (aluOp == CMP) ? (alu_operand_a >  alu_operand_b) : staleAbove;
  assign alu_error  = (aluOp == DIV) ? (alu_operand_b == 0) : staleError;

  always @(posedge clk) begin
    if (aluOp == CMP) begin
      staleBelow <= alu_below;
      staleEqual <= alu_equal;
      staleAbove <= alu_above;
    end
    if (aluOp == DIV) begin
      staleError <= alu_error;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one request, follow it to its response and score it.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input bit clrAtCapture);
    exp_t e;
    exp_t got;
    bit bypass;
    bit err;
    int n;
    int waitCnt;
    logic [35:0] snap;

    bypass = !legalOp(op);
`ifdef ALU_LOCAL_DIV0_EN
    if (op == DIV && b == 0) bypass = 1'b1;
`endif
    err      = !legalOp(op) || (op == DIV && b == 0);
    e.lat    = bypass ? 1 : 1 + SETTLE;
    e.result = (err || op == CMP) ? 32'h0 : refAlu(op, a, b);
    e.flags  = 4'b0000;
    if (op == CMP) e.flags = {1'b0, a > b, a == b, a < b};
    if (err) e.flags[3] = 1'b1;
    if (clrAtCapture) fqModel = 4'b0000;
    if (op == CMP) fqModel[2:0] = e.flags[2:0];
    if (err) fqModel[3] = 1'b1;
    e.fq = fqModel;
    sb.push_back(e);

    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    if (clrAtCapture && e.lat == 1) flags_clr = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flags_clr = 1'b0;
    req_op = 5'd0;

    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (n == 1) checkOutput("issue_instr", alu_instr, {32'h0, op, 27'h0});
      if (clrAtCapture && n == e.lat - 1) flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      n++;
    end
    if (!rsp_valid) begin
      checkOutput("rsp_valid_timeout", 64'd0, 64'd1);
      void'(sb.pop_front());
      return;
    end
    checkOutput("latency", n, e.lat);
    checkOutput("rsp_instr", alu_instr, 64'h0);

    snap = {rsp_result, rsp_flags};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_stable", {rsp_valid, req_ready, rsp_result, rsp_flags}, {1'b1, 1'b0, snap});
    end

    rsp_ready = 1'b1;
    got = sb.pop_front();
    checkOutput("rsp_result", rsp_result, got.result);
    checkOutput("rsp_flags", rsp_flags, got.flags);
    checkOutput("flags_q", flags_q, got.fq);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_instr", alu_instr, 64'h0);
    checkOutput("idle_ready", req_ready, 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_flags, flags_q}, 64'h0);
    checkOutput({tag, "_instr"}, alu_instr, 64'h0);
    checkOutput({tag, "_ops"}, {alu_operand_a, alu_operand_b}, 64'h0);
    checkOutput({tag, "_result"}, rsp_result, 64'h0);
  endtask

  task automatic clearFlags();
    @(negedge clk);
    flags_clr = 1'b1;
    @(posedge clk);
    #1;
    flags_clr = 1'b0;
    fqModel = 4'b0000;
    @(negedge clk);
    checkOutput("flags_clr", flags_q, fqModel);
  endtask

  // Reset while a MUL is settling: everything drops, no response follows.
  task automatic resetDuringOp();
    bit sawRsp;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MUL;
    req_a = 32'h1234;
    req_b = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midop_rst");
    fqModel = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_ready", req_ready, 64'd1);
    sawRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("no_rsp_after_rst", sawRsp, 64'd0);
  endtask

  initial begin
    #12;
    checkResetOutputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_rst", req_ready, 64'd1);

    applyStimulus(ADD, 32'd5, 32'd7, 0, 1'b0);
    applyStimulus(CMP, 32'd9, 32'd4, 0, 1'b0);
    applyStimulus(CMP, 32'd4, 32'd4, 0, 1'b0);
    applyStimulus(ADD, 32'd1, 32'd1, 0, 1'b0);
    applyStimulus(DIV, 32'd10, 32'd0, 0, 1'b0);
    clearFlags();
    applyStimulus(DIV, 32'd10, 32'd0, 0, 1'b1);
    applyStimulus(DIV, 32'd100, 32'd7, 0, 1'b0);
    applyStimulus(5'd20, 32'd1, 32'd2, 4, 1'b0);
    resetDuringOp();
    applyStimulus(SUB, 32'd3, 32'd5, 0, 1'b0);
    applyStimulus(SHL, 32'd1, 32'd4, 0, 1'b0);
    applyStimulus(MUL, 32'h00010001, 32'h00010001, 0, 1'b0);
    applyStimulus(ANDo, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
    applyStimulus(ORo, 32'hF000_0001, 32'h0000_8010, 0, 1'b0);
    applyStimulus(SHR, 32'h8000_0000, 32'd31, 0, 1'b0);
    applyStimulus(NOTo, 32'h0F0F_0F0F, 32'h1234, 0, 1'b0);
    applyStimulus(CMP, 32'd2, 32'd9, 0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=%0d expected=%0d", 0, 1);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
